// File: rtl/nes_joypad_pkg.sv
// rtl/nes_joypad_pkg.sv - shared NES joypad constants, types and helpers
// Purpose: button bit indices, read-counter limit, the synchronized input
//          bundle type and the turbo-merge helper used by nes_joypad.
// Ports:   none (package).
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int         NUM_BTN  = 8;
  // Read counter stops here: every bit of the report has been shifted out.
  localparam logic [3:0] CNT_MAX  = 4'd8;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Everything that crosses into the clk domain, synchronized as one word.
  typedef struct packed {
    logic [1:0] turbo_p1;
    logic [1:0] turbo_p0;
    btn_vec_t   btn_p1;
    btn_vec_t   btn_p0;
  } pad_in_t;

  // A and B read as pressed while turbo is enabled and the phase is high.
  function automatic btn_vec_t eff_vector(btn_vec_t btn, logic [1:0] turbo, logic phase);
    btn_vec_t v;
    v         = btn;
    v[BTN_A]  = btn[BTN_A] | (turbo[0] & phase);
    v[BTN_B]  = btn[BTN_B] | (turbo[1] & phase);
    return v;
  endfunction

endpackage

// File: rtl/nes_joypad_if.sv
// rtl/nes_joypad_if.sv - APU/CPU-side controller port bus
// Purpose: groups the latch lines, per-port read strobes and serial data.
// Ports:   ctrl_strobe[2:0] (OUT lines, bit 0 = latch), ctrl_out[1:0]
//          (read strobe per port), ctrl_data[1:0] (serial bit per port).
//          master = CPU/APU side, slave = joypad side.
interface nes_joypad_if;
  logic [2:0] ctrl_strobe;
  logic [1:0] ctrl_out;
  logic [1:0] ctrl_data;

  modport master (output ctrl_strobe, output ctrl_out, input ctrl_data);
  modport slave  (input ctrl_strobe, input ctrl_out, output ctrl_data);
endinterface

// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - one controller port: parallel latch, serial readout
// Purpose: 8-bit report shift register with latch reload and read-strobe
//          falling-edge shifting; shifts in 1s so over-reads return 1.
// Ports:   clk, rst (async, active-high); btn_i effective button vector;
//          latch_i strobe bit 0; rd_i read strobe; data_o serial bit (registered).
module joypad_port
  import nes_joypad_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  btn_vec_t btn_i,
  input  logic     latch_i,
  input  logic     rd_i,
  output logic     data_o
);

  btn_vec_t   sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_q;
  logic       rd_fall;

  // A read is consumed when the strobe drops, so a long strobe shifts once.
  assign rd_fall = rd_q & ~rd_i;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (latch_i) begin
      // Reload wins over a coincident read edge.
      sr_d  = btn_i;
      cnt_d = '0;
    end else if (rd_fall) begin
      sr_d = {1'b1, sr_q[NUM_BTN-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_i;
    end
  end

  assign data_o = sr_q[0];

endmodule

// File: rtl/nes_joypad.sv
// rtl/nes_joypad.sv - two-port NES joypad interface with turbo
// Purpose: synchronizes button/turbo inputs, runs the vblank frame counter
//          and turbo phase, and feeds two joypad_port instances.
// Ports:   clk, rst (async, active-high); bus (slave: strobe/read/data);
//          btn_p0/btn_p1 raw buttons; turbo_p0/turbo_p1 turbo enables
//          ([0]=A, [1]=B); vblank PPU vblank level in clk domain.
module nes_joypad
  import nes_joypad_pkg::*;
#(
  parameter int TURBO_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  nes_joypad_if.slave        bus,
  input  logic [7:0]         btn_p0,
  input  logic [7:0]         btn_p1,
  input  logic [1:0]         turbo_p0,
  input  logic [1:0]         turbo_p1,
  input  logic               vblank
);

  localparam logic [7:0] FRAME_LAST = 8'(TURBO_DIV - 1);

  pad_in_t                   raw_in;
  pad_in_t [SYNC_STAGES-1:0] sync_q;
  pad_in_t                   pad_s;

  logic       vblank_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       phase_q, phase_d;

  btn_vec_t   eff_p0, eff_p1;
  logic [1:0] data;
  logic       unused_strobe;

  assign raw_in = {turbo_p1, turbo_p0, btn_p1, btn_p0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign pad_s = sync_q[SYNC_STAGES-1];

  // Frame counter advances on vblank rising edges; the phase flips on wrap.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (vblank && !vblank_q) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q    <= 1'b0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      vblank_q    <= vblank;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign eff_p0 = eff_vector(pad_s.btn_p0, pad_s.turbo_p0, phase_q);
  assign eff_p1 = eff_vector(pad_s.btn_p1, pad_s.turbo_p1, phase_q);

  joypad_port u_port0 (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (eff_p0),
    .latch_i (bus.ctrl_strobe[0]),
    .rd_i    (bus.ctrl_out[0]),
    .data_o  (data[0])
  );

  joypad_port u_port1 (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (eff_p1),
    .latch_i (bus.ctrl_strobe[0]),
    .rd_i    (bus.ctrl_out[1]),
    .data_o  (data[1])
  );

  assign bus.ctrl_data = data;

  // OUT[2:1] drive expansion-port hardware, not the standard pads.
  assign unused_strobe = &{1'b0, bus.ctrl_strobe[2:1]};

endmodule

// File: tb/tb_nes_joypad.sv
// tb/tb_nes_joypad.sv - scoreboard bench for nes_joypad
module tb_nes_joypad;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_p0, btn_p1;
  logic [1:0] turbo_p0, turbo_p1;
  logic       vblank;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q0[$];
  int exp_q1[$];

  nes_joypad_if bus ();

  nes_joypad #(.TURBO_DIV(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .btn_p0   (btn_p0),
    .btn_p1   (btn_p1),
    .turbo_p0 (turbo_p0),
    .turbo_p1 (turbo_p1),
    .vblank   (vblank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic latch_pulse();
    bus.ctrl_strobe = 3'b001;
    tick();
    bus.ctrl_strobe = 3'b000;
    tick();
  endtask

  // Expected serial stream for a latched vector: 8 button bits, then 1s.
  task automatic push_stream(input int port, input logic [7:0] v, input int extra);
    for (int i = 0; i < 8 + extra; i++) begin
      int b;
      b = (i < 8) ? int'(v[i]) : 1;
      if (port == 0) exp_q0.push_back(b);
      else           exp_q1.push_back(b);
    end
  endtask

  // One-cycle read on the masked ports; the CPU sees the bit before the shift.
  task automatic read(input string tag, input logic [1:0] mask);
    bus.ctrl_out = mask;
    tick();
    if (mask[0]) begin
      if (exp_q0.size() == 0) check({tag, "_sb0_empty"}, 1, 0);
      else check({tag, "_p0"}, int'(bus.ctrl_data[0]), exp_q0.pop_front());
    end
    if (mask[1]) begin
      if (exp_q1.size() == 0) check({tag, "_sb1_empty"}, 1, 0);
      else check({tag, "_p1"}, int'(bus.ctrl_data[1]), exp_q1.pop_front());
    end
    bus.ctrl_out = 2'b00;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    btn_p0 = '0; btn_p1 = '0; turbo_p0 = '0; turbo_p1 = '0; vblank = 1'b0;
    bus.ctrl_strobe = '0; bus.ctrl_out = '0;
    repeat (3) tick();
    check("reset_data", int'(bus.ctrl_data), 0);
    rst = 1'b0;
    tick();
    check("post_reset_data", int'(bus.ctrl_data), 0);
    check("post_reset_cnt0", int'(dut.u_port0.cnt_q), 0);

    // Basic report plus two over-reads.
    btn_p0 = 8'b1000_0001;
    settle();
    latch_pulse();
    push_stream(0, btn_p0, 2);
    for (int i = 0; i < 10; i++) read("basic", 2'b01);
    check("basic_cnt_sat", int'(dut.u_port0.cnt_q), 8);

    // Both ports read together with different patterns.
    btn_p0 = 8'h3C; btn_p1 = 8'hA5;
    settle();
    latch_pulse();
    push_stream(0, btn_p0, 1);
    push_stream(1, btn_p1, 1);
    for (int i = 0; i < 9; i++) read("dual", 2'b11);

    // Latch held high: reads never shift.
    btn_p0 = 8'h01;
    settle();
    bus.ctrl_strobe = 3'b001;
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_out = 2'b01;
      tick();
      check("hold_data_hi", int'(bus.ctrl_data[0]), 1);
      bus.ctrl_out = 2'b00;
      tick();
      check("hold_data_lo", int'(bus.ctrl_data[0]), 1);
      check("hold_cnt0", int'(dut.u_port0.cnt_q), 0);
    end
    bus.ctrl_strobe = 3'b000;
    tick();
    exp_q0.push_back(1);
    exp_q0.push_back(0);
    read("hold_after", 2'b01);
    read("hold_after", 2'b01);

    // Wide read strobe on port 1 shifts exactly once.
    btn_p1 = 8'h02;
    settle();
    latch_pulse();
    check("wide_before", int'(bus.ctrl_data[1]), 0);
    bus.ctrl_out = 2'b10;
    repeat (5) tick();
    check("wide_during", int'(bus.ctrl_data[1]), 0);
    bus.ctrl_out = 2'b00;
    tick();
    check("wide_after", int'(bus.ctrl_data[1]), 1);
    check("wide_cnt1", int'(dut.u_port1.cnt_q), 1);

    // Latch coinciding with a read falling edge: reload wins.
    btn_p0 = 8'h02;
    settle();
    latch_pulse();
    bus.ctrl_out = 2'b01;
    tick();
    bus.ctrl_out = 2'b00;
    bus.ctrl_strobe = 3'b001;
    tick();
    bus.ctrl_strobe = 3'b000;
    tick();
    check("coincide_data", int'(bus.ctrl_data[0]), 0);
    check("coincide_cnt0", int'(dut.u_port0.cnt_q), 0);

    // Reset in the middle of a read sequence.
    btn_p0 = 8'h0F;
    settle();
    latch_pulse();
    for (int i = 0; i < 3; i++) exp_q0.push_back(1);
    for (int i = 0; i < 3; i++) read("prerst", 2'b01);
    rst = 1'b1;
    #1;
    check("midrst_data", int'(bus.ctrl_data), 0);
    check("midrst_cnt0", int'(dut.u_port0.cnt_q), 0);
    repeat (2) tick();
    rst = 1'b0;
    btn_p0 = 8'hFF;
    settle();
    check("postrst_noshift", int'(bus.ctrl_data), 0);
    latch_pulse();
    push_stream(0, btn_p0, 0);
    for (int i = 0; i < 8; i++) read("postrst", 2'b01);

    // Turbo on A; frame counter starts from reset.
    btn_p0 = 8'h00; turbo_p0 = 2'b01;
    settle();
    for (int e = 1; e <= 4; e++) begin
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick();
      latch_pulse();
      check($sformatf("turbo_edge%0d", e), int'(bus.ctrl_data[0]), (e == 2 || e == 3) ? 1 : 0);
    end

    check("sb0_drained", exp_q0.size(), 0);
    check("sb1_drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_joypad.md
NES_JOYPAD -- requirements
Module: nes_joypad

Interface
REQ-001 Parameter TURBO_DIV, default 2, frames per turbo phase toggle; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on the button inputs; legal range 2..3.
REQ-003 clk  input  1  CPU clock (clk_cpu); the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ctrl_strobe  input  3  OUT[2:0] latch lines from the APU; only bit 0 is used (latch).
REQ-006 ctrl_out  input  2  per-port read strobe; high for each CPU read of $4016 (bit 0) or $4017 (bit 1).
REQ-007 ctrl_data  output  2  serial button bit per port; 1 = pressed.
REQ-008 btn_p0, btn_p1  input  8 each  asynchronous button state, order [0]=A,[1]=B,[2]=Select,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right; 1 = pressed.
REQ-009 turbo_p0, turbo_p1  input  2 each  turbo enables, [0]=A, [1]=B.
REQ-010 vblank  input  1  PPU vblank level, already in the clk domain.

Function
REQ-011 Each btn/turbo input bit SHALL pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-012 Frame counter: on each vblank rising edge (0->1 between consecutive cycles), frame_cnt SHALL increment; when frame_cnt reaches TURBO_DIV-1 it SHALL wrap to 0 and turbo_phase SHALL toggle in the same cycle.
REQ-013 Effective button vector per port SHALL be: bits 7:2 = synced btn; bit k (k=0,1) = synced btn[k] OR (synced turbo[k] AND turbo_phase).
REQ-014 Each port SHALL own an 8-bit shift register sr_n and a 4-bit read counter cnt_n (saturating at 8).
REQ-015 While ctrl_strobe[0]=1: sr_n <= effective vector and cnt_n <= 0 every cycle; reads SHALL NOT shift.
REQ-016 While ctrl_strobe[0]=0: on the falling edge of ctrl_out[n] (1 in previous cycle, 0 now), sr_n SHALL shift right with 1 inserted at bit 7, and cnt_n SHALL increment, saturating at 8.
REQ-017 ctrl_data[n] SHALL be sr_n[0] (registered output, no combinational path from inputs); after 8 shifts it SHALL read 1 indefinitely until the next latch.
REQ-018 A read strobe held high for multiple cycles SHALL cause exactly one shift, at its falling edge.
REQ-019 If ctrl_strobe[0] is high in the cycle of a ctrl_out[n] falling edge, the reload SHALL win and no shift SHALL occur.
REQ-020 Ports SHALL be fully independent; simultaneous falling edges on both ctrl_out bits SHALL shift both registers.
REQ-021 Latch falling edge (ctrl_strobe[0] 1->0) SHALL freeze sr_n at the value loaded in the final high cycle.

Reset
REQ-022 On rst: sr_0, sr_1 = 8'h00; cnt_n = 0; ctrl_data = 2'b00; frame_cnt = 0; turbo_phase = 0; all synchronizer and edge-detect flops = 0.
REQ-023 Reset asserted mid-read-sequence SHALL discard all shift state; after release the block SHALL behave as freshly reset, with no shift until a new falling edge of ctrl_out.

Structure
REQ-024 The button bit-index constants (BTN_A..BTN_RIGHT) SHALL live in the shared nes package.
REQ-025 Port logic SHALL be one sub-module, joypad_port (synchronized button vector in, latch, read strobe, serial bit out), instantiated twice; the turbo/frame logic SHALL stay in nes_joypad.

Verification
REQ-026 btn_p0=8'b1000_0001, pulse latch, 8 one-cycle reads -> ctrl_data[0] sequence 1,0,0,0,0,0,0,1; 9th and 10th reads -> 1,1.
REQ-027 Latch held high, 3 reads with btn_p0[0]=1 -> ctrl_data[0]=1 on every read, cnt_0 stays 0.
REQ-028 turbo_p0[0]=1, btn_p0=0, TURBO_DIV=2, 4 vblank rising edges -> turbo_phase toggles after the 2nd and 4th edges, so latched bit 0 reads 1 only between those toggles.
REQ-029 One 5-cycle-wide read on port 1 after a latch with btn_p1=8'h02 -> exactly one shift; ctrl_data[1] = 0 before the read, 1 after.
REQ-030 rst asserted after 3 of 8 reads -> ctrl_data=2'b00 immediately; next latch with btn_p0=8'hFF -> eight 1s.
REQ-031 Latch high coinciding with a ctrl_out[0] falling edge -> no shift; ctrl_data[0] = btn_p0[0].
